// File: rtl/pl_scoreboard_pkg.sv
// Shared pipeline constants for the ID-stage hazard scoreboard.
// Holds the default sizing and the issue_lat encodings used by decode.
package pl_scoreboard_pkg;

  localparam int unsigned NREG_DEF = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned LW_DEF   = 3;
  localparam int unsigned PCW_DEF  = 32;

  localparam int unsigned LAT_ALU  = 0;
  localparam int unsigned LAT_LOAD = 1;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: cycles-until-forwardable counter plus a write-pending bit.
// Issue set beats WB clear; reset and flush drop everything.
module sb_entry
  import pl_scoreboard_pkg::*;
#(
  parameter int unsigned LW = LW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          set,
  input  logic [LW-1:0] lat,
  input  logic          clr,
  output logic [LW-1:0] cnt,
  output logic          pend
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      cnt  <= '0;
      pend <= 1'b0;
    end else begin
      if (set) begin
        cnt <= lat;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (set) begin
        pend <= 1'b1;
      end else if (clr) begin
        pend <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pl_scoreboard.sv
// ID-stage scoreboard: detects RAW/WAW hazards against in-flight producers and
// stalls issue until results become forwardable. Control only, no data path.
module pl_scoreboard
  import pl_scoreboard_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned LW   = LW_DEF,
  parameter int unsigned PCW  = PCW_DEF
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs,
  input  logic [AW-1:0]   issue_rt,
  input  logic            issue_use_rs,
  input  logic            issue_use_rt,
  input  logic            issue_wr,
  input  logic [AW-1:0]   issue_rdes,
  input  logic [LW-1:0]   issue_lat,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rdes,
  input  logic            flush,
  output logic            stall,
  output logic            issue_fire,
  output logic [NREG-1:0] pend_vec,
  output logic [PCW-1:0]  stall_cnt
);

  logic [LW-1:0]   cnt [NREG];
  logic [NREG-1:0] pend;
  logic            raw_rs, raw_rt, waw, set_en;

  // r0 is hard-wired zero and never tracked
  assign cnt[0]  = '0;
  assign pend[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    sb_entry #(
      .LW(LW)
    ) u_entry (
      .clk  (CLK),
      .reset(Reset),
      .flush(flush),
      .set  (set_en && (issue_rdes == AW'(r))),
      .lat  (issue_lat),
      .clr  (wb_valid && (wb_rdes == AW'(r))),
      .cnt  (cnt[r]),
      .pend (pend[r])
    );
  end

  always_comb begin
    raw_rs     = issue_use_rs && (issue_rs != '0) && (cnt[issue_rs] != '0);
    raw_rt     = issue_use_rt && (issue_rt != '0) && (cnt[issue_rt] != '0);
    waw        = issue_wr && (issue_rdes != '0) && (cnt[issue_rdes] > issue_lat);
    stall      = issue_valid && !flush && !Reset && (raw_rs || raw_rt || waw);
    issue_fire = issue_valid && !stall && !flush && !Reset;
    set_en     = issue_fire && issue_wr;
  end

  assign pend_vec = pend;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pl_scoreboard.sv
// Self-checking bench for pl_scoreboard: directed scenarios plus random issue
// traffic checked against a timestamp-based model of result availability.
module tb_pl_scoreboard;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        issue_valid;
  logic [4:0]  issue_rs, issue_rt, issue_rdes, wb_rdes;
  logic        issue_use_rs, issue_use_rt, issue_wr, wb_valid, flush;
  logic [2:0]  issue_lat;
  logic        stall, issue_fire;
  logic [31:0] pend_vec;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: absolute cycle at which each register's result becomes forwardable.
  longint     avail [32];
  bit  [31:0] m_pend;
  longint     m_scnt;
  longint     cyc;

  pl_scoreboard dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .issue_valid (issue_valid),
    .issue_rs    (issue_rs),
    .issue_rt    (issue_rt),
    .issue_use_rs(issue_use_rs),
    .issue_use_rt(issue_use_rt),
    .issue_wr    (issue_wr),
    .issue_rdes  (issue_rdes),
    .issue_lat   (issue_lat),
    .wb_valid    (wb_valid),
    .wb_rdes     (wb_rdes),
    .flush       (flush),
    .stall       (stall),
    .issue_fire  (issue_fire),
    .pend_vec    (pend_vec),
    .stall_cnt   (stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint remaining(input int r);
    if (r == 0 || avail[r] <= cyc) return 0;
    return avail[r] - cyc;
  endfunction

  task automatic idle();
    issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rs = 0; issue_use_rt = 0;
    issue_wr = 0; issue_rdes = 0; issue_lat = 0; wb_valid = 0; wb_rdes = 0; flush = 0;
  endtask

  task automatic issue(input int rs, input bit urs, input int rt, input bit urt,
                       input bit wr, input int rd, input int lat);
    issue_valid = 1; issue_rs = 5'(rs); issue_use_rs = urs; issue_rt = 5'(rt);
    issue_use_rt = urt; issue_wr = wr; issue_rdes = 5'(rd); issue_lat = 3'(lat);
  endtask

  // Check outputs against the model for this cycle, then advance one clock.
  task automatic go();
    bit  hz, e_stall, e_fire;
    #1;
    hz = (issue_use_rs && remaining(int'(issue_rs)) != 0) ||
         (issue_use_rt && remaining(int'(issue_rt)) != 0) ||
         (issue_wr && remaining(int'(issue_rdes)) > longint'(issue_lat));
    e_stall = issue_valid && !flush && !Reset && hz;
    e_fire  = issue_valid && !flush && !Reset && !hz;
    chk("stall", 64'(stall), 64'(e_stall));
    chk("issue_fire", 64'(issue_fire), 64'(e_fire));
    chk("pend_vec", 64'(pend_vec), 64'(m_pend));
    chk("stall_cnt", 64'(stall_cnt), 64'(m_scnt));
    @(posedge CLK);
    if (Reset || flush) begin
      foreach (avail[i]) avail[i] = 0;
      m_pend = '0;
      if (Reset) m_scnt = 0;
    end else begin
      if (wb_valid) m_pend[wb_rdes] = 1'b0;
      if (e_fire && issue_wr && issue_rdes != 0) begin
        avail[issue_rdes]  = cyc + 1 + longint'(issue_lat);
        m_pend[issue_rdes] = 1'b1;
      end
    end
    if (e_stall && m_scnt != 64'hFFFF_FFFF) m_scnt++;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1;
    go();
    Reset = 0;
  endtask

  initial begin
    int  n;
    bit  done;
    idle();
    Reset  = 1;
    cyc    = 100;
    m_pend = '0;
    m_scnt = 0;
    foreach (avail[i]) avail[i] = 0;
    @(posedge CLK);
    #1;
    go();
    go();
    Reset = 0;
    chk("reset_pend", 64'(pend_vec), 64'(0));
    chk("reset_scnt", 64'(stall_cnt), 64'(0));

    // ALU producer r8, immediate consumer r9 = r8 + r8
    issue(0, 0, 0, 0, 1, 8, 0);
    go();
    issue(8, 1, 8, 1, 1, 9, 0);
    #1 chk("s1_stall", 64'(stall), 64'(0));
    go();
    idle();
    chk("s1_pend8", 64'(pend_vec[8]), 64'(1));
    wb_valid = 1; wb_rdes = 8;
    go();
    wb_rdes = 9;
    go();
    chk("s1_pend_clr", 64'(pend_vec[8]), 64'(0));

    // Load-use: one stall cycle
    do_reset();
    issue(0, 0, 0, 0, 1, 8, 1);
    go();
    issue(8, 1, 0, 0, 1, 11, 0);
    #1 chk("s2_stall", 64'(stall), 64'(1));
    go();
    #1 chk("s2_fire", 64'(issue_fire), 64'(1));
    go();
    idle();
    chk("s2_scnt", 64'(stall_cnt), 64'(1));

    // Latency-3 producer on r10, dependent on rt
    issue(0, 0, 0, 0, 1, 10, 3);
    go();
    issue(0, 0, 10, 1, 0, 0, 0);
    n = 0; done = 0;
    for (int i = 0; i < 10 && !done; i++) begin
      #1;
      if (stall) begin n++; go(); end
      else done = 1;
    end
    chk("s3_stalls", 64'(n), 64'(3));
    go();
    issue(0, 0, 0, 0, 1, 10, 3);
    go();
    issue(0, 0, 10, 0, 0, 0, 0);
    #1 chk("s3_no_use", 64'(stall), 64'(0));
    go();

    // r0 never tracked
    issue(0, 0, 0, 0, 1, 0, 7);
    go();
    issue(0, 1, 0, 1, 1, 0, 0);
    #1 chk("s4_stall", 64'(stall), 64'(0));
    go();
    chk("s4_pend0", 64'(pend_vec[0]), 64'(0));

    // Flush clears in-flight state and suppresses the concurrent issue
    issue(0, 0, 0, 0, 1, 5, 3);
    go();
    issue(5, 1, 0, 0, 1, 6, 3);
    flush = 1;
    #1 chk("s5_fl_stall", 64'(stall), 64'(0));
    chk("s5_fl_fire", 64'(issue_fire), 64'(0));
    go();
    flush = 0;
    issue(5, 1, 0, 0, 0, 0, 0);
    #1 chk("s5_stall", 64'(stall), 64'(0));
    chk("s5_fire", 64'(issue_fire), 64'(1));
    chk("s5_pend", 64'(pend_vec), 64'(0));
    go();

    // Same-cycle WB clear and issue set on r7; then reset mid-latency
    issue(0, 0, 0, 0, 1, 7, 2);
    go();
    issue(0, 0, 0, 0, 1, 7, 2);
    wb_valid = 1; wb_rdes = 7;
    go();
    idle();
    chk("s6_pend7", 64'(pend_vec[7]), 64'(1));
    issue(0, 0, 0, 0, 1, 12, 5);
    go();
    issue(12, 1, 0, 0, 0, 0, 0);
    Reset = 1;
    #1 chk("s6_rst_fire", 64'(issue_fire), 64'(0));
    go();
    Reset = 0;
    #1 chk("s6_stall", 64'(stall), 64'(0));
    chk("s6_pend", 64'(pend_vec), 64'(0));
    chk("s6_scnt", 64'(stall_cnt), 64'(0));
    go();

    // Random traffic over a narrow register range to provoke hazards
    for (int i = 0; i < 600; i++) begin
      idle();
      Reset = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 9) < 8) begin
        issue($urandom_range(0, 11), 1'($urandom), $urandom_range(0, 11), 1'($urandom),
              1'($urandom), $urandom_range(0, 11), $urandom_range(0, 7));
      end
      wb_valid = 1'($urandom);
      wb_rdes  = 5'($urandom_range(0, 11));
      go();
    end
    Reset = 0;
    idle();
    go();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pl_scoreboard.md
PL_SCOREBOARD -- requirements
Module: pl_scoreboard

Interface
REQ-001 Parameter NREG, default 32, number of architectural registers; register 0 is hard-wired zero.
REQ-002 Parameter AW, default 5, register-index width, AW = clog2(NREG).
REQ-003 Parameter LW, default 3, latency-counter width; maximum producer latency is 2^LW-1.
REQ-004 Parameter PCW, default 32, stall performance-counter width.
REQ-005 CLK  in  1  sole clock; all state updates on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 issue_valid  in  1  ID stage presents an instruction.
REQ-008 issue_rs, issue_rt  in  AW each  source register indices.
REQ-009 issue_use_rs, issue_use_rt  in  1 each  source actually read.
REQ-010 issue_wr  in  1  instruction writes a destination.
REQ-011 issue_rdes  in  AW  destination index.
REQ-012 issue_lat  in  LW  cycles until the result is forwardable (0 = ALU result, 1 = load).
REQ-013 wb_valid, wb_rdes  in  1, AW  WB-stage register-file write.
REQ-014 flush  in  1  exception/interrupt pipeline flush.
REQ-015 stall  out  1  hold PC and IF/ID, bubble ID/EX.
REQ-016 issue_fire  out  1  issue_valid && !stall.
REQ-017 pend_vec  out  NREG  per-register write-pending bits.
REQ-018 stall_cnt  out  PCW  cycles with stall high.

Function
REQ-019 Per register r the block SHALL hold cnt[r] (LW bits) and pend[r] (1 bit); r = 0 SHALL never be set.
REQ-020 stall SHALL be combinational from current state and ID inputs: issue_valid && (RAW_rs || RAW_rt || WAW).
REQ-021 RAW_rs = issue_use_rs && issue_rs != 0 && cnt[issue_rs] != 0; RAW_rt likewise.
REQ-022 WAW = issue_wr && issue_rdes != 0 && cnt[issue_rdes] > issue_lat.
REQ-023 On issue_fire with issue_wr and issue_rdes != 0: cnt[issue_rdes] <= issue_lat, pend[issue_rdes] <= 1.
REQ-024 Every other nonzero cnt SHALL decrement by 1 per cycle, saturating at 0.
REQ-025 Consequently: lat 0 -> dependent in next cycle not stalled; lat N -> exactly N stall cycles for a back-to-back dependent.
REQ-026 wb_valid SHALL clear pend[wb_rdes]; cnt is unaffected.
REQ-027 Same-cycle issue-set and wb-clear on one register: the issue set SHALL win (pend = 1).
REQ-028 flush SHALL clear all cnt and pend next cycle, SHALL force stall = 0 and issue_fire = 0 that cycle, and SHALL not record an issue.
REQ-029 stall_cnt SHALL increment on each cycle stall = 1, saturating at all-ones.
REQ-030 issue_valid = 0 SHALL force stall = 0 regardless of state.

Reset
REQ-031 Reset SHALL clear all cnt, pend, and stall_cnt at the next edge; Reset overrides flush, issue, and wb.
REQ-032 During and after Reset, stall, issue_fire, pend_vec, and stall_cnt SHALL be 0 until the first post-reset issue.
REQ-033 Reset asserted mid-latency SHALL discard outstanding counts; no residual stall afterwards.

Structure
REQ-034 The shared pipeline package SHALL hold the default NREG, AW, LW, and PCW constants and the issue_lat encodings LAT_ALU = 0 and LAT_LOAD = 1.
REQ-035 One sub-module, sb_entry, holds a single register's cnt/pend with set/decrement/clear logic, instantiated NREG-1 times by generate.
REQ-036 The block SHALL contain no data path; forwarding muxes remain in the existing forward unit.

Verification
REQ-037 Scenario 1: issue add r8 (lat 0), next cycle add r9 = r8 + r8 -> stall = 0 both cycles, pend_vec[8] = 1 until wb r8.
REQ-038 Scenario 2: lw r8 (lat 1), next cycle use rs = r8 -> stall = 1 for exactly 1 cycle, then issue_fire = 1; stall_cnt = 1.
REQ-039 Scenario 3: producer to r10 with lat 3, dependent on rt = r10 -> 3 stall cycles; use_rt = 0 -> 0 stalls.
REQ-040 Scenario 4: writes and reads to r0 with any lat -> stall never asserted, pend_vec[0] = 0.
REQ-041 Scenario 5: lat 3 pending on r5, flush after 1 cycle -> next cycle cnt/pend cleared, dependent issues with stall = 0.
REQ-042 Scenario 6: wb_valid r7 with same-cycle issue writing r7 -> pend_vec[7] = 1; Reset mid-latency -> all outputs 0 next cycle.
